// File: rtl/instr_fetch.sv
// Instruction fetch front end: 32-bit program memory reads split into 16-bit Thumb halfwords.
// Latency: first halfword visible two edges after reset release with a zero-wait memory.
// Backpressure: instr_ready stalls the halfword FIFO; new fetches start only when two entries are free.
module instr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [15:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_mem_addr;
  logic          r_drop;

  logic [15:0]   r_fifo_dat [DEPTH];
  logic [31:0]   r_fifo_pc  [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_ack;
  logic          w_push;
  logic          w_push_two;
  logic [1:0]    w_push_n;
  logic [CW:0]   w_free;
  logic          w_start;
  logic [PW-1:0] w_wr_ptr1;
  logic [15:0]   w_first_dat;

  // A redirect flushes the FIFO, so a pop on the same edge must not be counted.
  assign w_pop      = instr_valid && instr_ready && !redirect_valid;
  assign w_ack      = (r_state == S_WAIT) && mem_ack;
  assign w_push     = w_ack && !r_drop && !redirect_valid;
  // An odd-halfword fetch_pc only consumes the upper half of the word.
  assign w_push_two = w_push && !r_fetch_pc[1];
  assign w_push_n   = w_push ? (w_push_two ? 2'd2 : 2'd1) : 2'd0;
  // Free space is evaluated after this edge's pop; two slots guarantee no overflow.
  assign w_free     = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_pop);
  assign w_start    = (r_state == S_IDLE) && !redirect_valid && (w_free >= (CW+1)'(2));
  assign w_wr_ptr1  = r_wr_ptr + PW'(1);
  assign w_first_dat = r_fetch_pc[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: a request stays open until acked, even across redirects.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next_state = S_WAIT;
      S_WAIT:  if (mem_ack) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs: memory request from state, Decode view of the FIFO head (zeroed when empty).
  always_comb begin
    mem_req     = (r_state == S_WAIT);
    mem_addr    = r_mem_addr;
    instr_valid = (r_count != '0);
    instruction = 16'h0000;
    instr_pc    = 32'h0000_0000;
    if (instr_valid) begin
      instruction = r_fifo_dat[r_rd_ptr];
      instr_pc    = r_fifo_pc[r_rd_ptr];
    end
  end

  // Fetch pointer, request address and the stale-response drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC & ~32'h1;
      r_mem_addr <= RESET_PC & ~32'h3;
      r_drop     <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~32'h1;
        // Outstanding request keeps its address; its data is thrown away later.
        r_drop     <= (r_state == S_WAIT) && !mem_ack;
      end else begin
        if (w_ack) r_drop <= 1'b0;
        if (w_push) r_fetch_pc <= r_fetch_pc + (w_push_two ? 32'd4 : 32'd2);
      end
      if (w_start) r_mem_addr <= {r_fetch_pc[31:2], 2'b00};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
      r_count  <= r_count + CW'(w_push_n) - CW'(w_pop);
    end
  end

  // FIFO storage: little-endian split, low halfword first when word-aligned.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dat[r_wr_ptr] <= w_first_dat;
      r_fifo_pc[r_wr_ptr]  <= r_fetch_pc;
      if (w_push_two) begin
        r_fifo_dat[w_wr_ptr1] <= mem_rdata[31:16];
        r_fifo_pc[w_wr_ptr1]  <= r_fetch_pc + 32'd2;
      end
    end
  end

endmodule
